row_compositor: RTL and testbench

ROW_COMPOSITOR -- requirements
Module: row_compositor

---
 rtl/row_compositor_if.sv | 32 +++
 rtl/row_compositor.sv | 164 ++++++++++++++++
 tb/tb_row_compositor.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_compositor_if.sv
// Scanline/memory bus between the row compositor and its beam timing, memory and draw control.
// master drives requests and row data; slave is the compositor.
interface row_compositor_if #(
  parameter int unsigned COLS = 640,
  parameter int unsigned BPP  = 1
);
  logic                   noise;
  logic                   drawRequest;
  logic [1:0]             mode;
  logic [BPP-1:0]         fillColor;
  logic                   reading;
  logic [COLS*BPP-1:0]    readRow;
  logic                   displayActive;
  logic [8:0]             row;
  logic [9:0]             column;
  logic [COLS*BPP-1:0]    writeRow;
  logic [COLS*BPP-1:0]    prevRow;
  logic                   drawing;
  logic                   frameDone;

  modport master (
    output noise, drawRequest, mode, fillColor, reading, readRow,
           displayActive, row, column,
    input  writeRow, prevRow, drawing, frameDone
  );

  modport slave (
    input  noise, drawRequest, mode, fillColor, reading, readRow,
           displayActive, row, column,
    output writeRow, prevRow, drawing, frameDone
  );
endinterface

// File: rtl/row_compositor.sv
// Row compositor: keeps the last two loaded rows and paints into the working row while a draw window is open.
// Build option: define ROW_COMPOSITOR_INVERT_EN to make draw mode 3 invert pixels; otherwise mode 3 leaves them unchanged.
//
// Draw-window FSM (drawing = state[1], pending request = state[0])
//   state         | meaning
//   ST_IDLE       | no window, no request waiting
//   ST_ARMED      | request waiting for the start row (VIS_ROWS+1)
//   ST_DRAW       | window open, no further request
//   ST_DRAW_ARMED | window open, another request queued for the next start row
module row_compositor #(
  parameter int unsigned COLS     = 640,
  parameter int unsigned BPP      = 1,
  parameter int unsigned VIS_ROWS = 480
) (
  input logic             clkDiv,
  input logic             rst,
  row_compositor_if.slave bus
);

  localparam int unsigned ROW_W = COLS * BPP;
  localparam int unsigned IDX_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] MODE_NOISE  = 2'd0;
  localparam logic [1:0] MODE_FILL   = 2'd1;
  localparam logic [1:0] MODE_CLEAR  = 2'd2;
  localparam logic [1:0] MODE_INVERT = 2'd3;

  localparam logic [1:0] ST_IDLE       = 2'b00;
  localparam logic [1:0] ST_ARMED      = 2'b01;
  localparam logic [1:0] ST_DRAW       = 2'b10;
  localparam logic [1:0] ST_DRAW_ARMED = 2'b11;

  logic [ROW_W-1:0] row0;
  logic [ROW_W-1:0] row1;
  logic [ROW_W-1:0] row1Next;
  logic             readingQ;
  logic             loadEdge;

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic             startWin;
  logic             stopWin;
  logic             atStartRow;
  logic             atStopRow;
  logic             frameDone;
  logic [1:0]       activeMode;
  logic [BPP-1:0]   activeColor;

  logic [15:0]      lfsr;
  logic [15:0]      lfsrShift;
  logic [15:0]      lfsrNext;
  logic             lfsrFb;

  logic             colInRange;
  logic             pixWrite;
  logic [IDX_W-1:0] pixBase;
  logic [BPP-1:0]   curPix;
  logic [BPP-1:0]   newPix;

  assign loadEdge   = bus.reading & ~readingQ;
  assign atStartRow = (32'(bus.row) == VIS_ROWS + 1);
  assign atStopRow  = (32'(bus.row) == VIS_ROWS);

  always_comb begin
    stateNext = state;
    startWin  = 1'b0;
    stopWin   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.drawRequest) stateNext = ST_ARMED;
      end
      ST_ARMED: begin
        if (atStartRow) begin
          startWin  = 1'b1;
          stateNext = bus.drawRequest ? ST_DRAW_ARMED : ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (atStopRow) begin
          stopWin   = 1'b1;
          stateNext = bus.drawRequest ? ST_ARMED : ST_IDLE;
        end else if (bus.drawRequest) begin
          stateNext = ST_DRAW_ARMED;
        end
      end
      ST_DRAW_ARMED: begin
        // A request queued mid-window only re-arms; the open window keeps its end row.
        if (atStopRow) begin
          stopWin   = 1'b1;
          stateNext = ST_ARMED;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Galois step; the entropy bit perturbs the feedback, and the all-zero lock-up state is replaced by the seed.
  always_comb begin
    lfsrFb    = lfsr[0] ^ bus.noise;
    lfsrShift = {1'b0, lfsr[15:1]} ^ (lfsrFb ? LFSR_TAPS : 16'h0000);
    lfsrNext  = (lfsrShift == 16'h0000) ? LFSR_SEED : lfsrShift;
  end

  assign colInRange = (32'(bus.column) < COLS);
  assign pixWrite   = state[1] & bus.displayActive & colInRange;
  assign pixBase    = IDX_W'(32'(bus.column) * BPP);

  // The pixel edit is applied on top of a row being loaded in the same cycle.
  always_comb begin
    row1Next = loadEdge ? bus.readRow : row1;
    curPix   = '0;
    newPix   = '0;
    if (pixWrite) begin
      curPix = row1Next[pixBase +: BPP];
      case (activeMode)
        MODE_NOISE:  newPix = lfsr[BPP-1:0];
        MODE_FILL:   newPix = activeColor;
        MODE_CLEAR:  newPix = '0;
        MODE_INVERT: begin
`ifdef ROW_COMPOSITOR_INVERT_EN
          newPix = ~curPix;
`else
          newPix = curPix;
`endif
        end
        default:     newPix = curPix;
      endcase
      row1Next[pixBase +: BPP] = newPix;
    end
  end

  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      row0        <= '0;
      row1        <= '0;
      readingQ    <= 1'b0;
      state       <= ST_IDLE;
      frameDone   <= 1'b0;
      activeMode  <= MODE_NOISE;
      activeColor <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      readingQ  <= bus.reading;
      row1      <= row1Next;
      state     <= stateNext;
      frameDone <= stopWin;
      lfsr      <= lfsrNext;
      if (loadEdge) row0 <= row1;
      if (startWin) begin
        activeMode  <= bus.mode;
        activeColor <= bus.fillColor;
      end
    end
  end

  assign bus.writeRow  = row1;
  assign bus.prevRow   = row0;
  assign bus.drawing   = state[1];
  assign bus.frameDone = frameDone;

endmodule

// File: tb/tb_row_compositor.sv
// Directed bench for row_compositor: a 1bpp and a 4bpp instance, expectations queued in a scoreboard.
module tb_row_compositor;

  localparam int WMAX = 2560;

  logic clkDiv;
  logic rst;

  row_compositor_if #(.COLS(640), .BPP(1)) ifA ();
  row_compositor_if #(.COLS(640), .BPP(4)) ifB ();

  row_compositor #(.COLS(640), .BPP(1), .VIS_ROWS(480)) dutA (
    .clkDiv(clkDiv),
    .rst   (rst),
    .bus   (ifA)
  );

  row_compositor #(.COLS(640), .BPP(4), .VIS_ROWS(480)) dutB (
    .clkDiv(clkDiv),
    .rst   (rst),
    .bus   (ifB)
  );

  initial clkDiv = 1'b0;
  always #5 clkDiv = ~clkDiv;

  typedef struct {
    string           tag;
    logic [WMAX-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   fdA      = 0;

  logic [15:0] modelLfsr;

  function automatic logic [15:0] lfsrStep(input logic [15:0] cur, input logic nz);
    logic        fb;
    logic [15:0] nxt;
    fb  = cur[0] ^ nz;
    nxt = (cur >> 1) ^ (fb ? 16'hB400 : 16'h0000);
    return (nxt == 16'h0000) ? 16'hACE1 : nxt;
  endfunction

  always @(posedge clkDiv or posedge rst)
    if (rst) modelLfsr <= 16'hACE1;
    else     modelLfsr <= lfsrStep(modelLfsr, ifA.noise);

  always @(negedge clkDiv)
    if (ifA.frameDone === 1'b1) fdA++;

  task automatic tick();
    @(posedge clkDiv);
    #1;
  endtask

  task automatic push(input string tag, input logic [WMAX-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [WMAX-1:0] obs);
    exp_t e;
    int   firstDiff;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs[63:0]);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      failures++;
      firstDiff = -1;
      for (int i = WMAX - 1; i >= 0; i--)
        if (obs[i] !== e.val[i]) firstDiff = i;
      $error("FAIL %s observed[63:0]=%h expected[63:0]=%h first_diff_bit=%0d",
             e.tag, obs[63:0], e.val[63:0], firstDiff);
    end
  endtask

  logic [639:0]  onesA, patA, patC, expRowA, prevExpA;
  logic [2559:0] expRowB;
  int            zeroHits, modelMiss;

  initial begin
    onesA = '1;
    for (int b = 0; b < 80; b++) begin
      patA[b*8 +: 8] = 8'hA5;
      patC[b*8 +: 8] = 8'h33;
    end

    rst = 1'b1;
    ifA.noise = 0; ifA.drawRequest = 0; ifA.mode = 0; ifA.fillColor = 0; ifA.reading = 0;
    ifA.readRow = '0; ifA.displayActive = 0; ifA.row = 0; ifA.column = 0;
    ifB.noise = 0; ifB.drawRequest = 0; ifB.mode = 0; ifB.fillColor = 0; ifB.reading = 0;
    ifB.readRow = '0; ifB.displayActive = 0; ifB.row = 0; ifB.column = 0;
    repeat (3) tick();

    // reset state
    push("rst_writeRow", '0);          popCheck(WMAX'(ifA.writeRow));
    push("rst_prevRow", '0);           popCheck(WMAX'(ifA.prevRow));
    push("rst_drawing", '0);           popCheck(WMAX'(ifA.drawing));
    push("rst_frameDone", '0);         popCheck(WMAX'(ifA.frameDone));
    push("rst_lfsr", WMAX'(16'hACE1)); popCheck(WMAX'(dutA.lfsr));
    rst = 1'b0;
    tick();

    // row load on reading rising edge, none while held
    ifA.readRow = onesA; ifA.reading = 1;
    push("load1_writeRow", WMAX'(onesA));
    push("load1_prevRow", '0);
    tick();
    popCheck(WMAX'(ifA.writeRow));
    popCheck(WMAX'(ifA.prevRow));
    ifA.readRow = '0;
    push("hold_writeRow", WMAX'(onesA));
    repeat (3) tick();
    popCheck(WMAX'(ifA.writeRow));
    ifA.reading = 0;
    tick();
    ifA.reading = 1; ifA.readRow = patA;
    push("load2_writeRow", WMAX'(patA));
    push("load2_prevRow", WMAX'(onesA));
    tick();
    popCheck(WMAX'(ifA.writeRow));
    popCheck(WMAX'(ifA.prevRow));
    ifA.reading = 0;
    tick();

    // fill window start; mode/colour inputs change afterwards and must not matter
    ifA.mode = 2'd1; ifA.fillColor = 1'b1; ifA.row = 9'd481; ifA.drawRequest = 1;
    tick();
    ifA.drawRequest = 0;
    push("fill_start_drawing", WMAX'(1'b1));
    tick();
    popCheck(WMAX'(ifA.drawing));
    ifA.mode = 2'd2; ifA.fillColor = 1'b0; ifA.row = 9'd0;

    // same-cycle load and pixel write at column 3
    ifA.readRow = patC; ifA.reading = 1; ifA.displayActive = 1; ifA.column = 10'd3;
    expRowA = patC; expRowA[3] = 1'b1;
    push("loadwrite_writeRow", WMAX'(expRowA));
    push("loadwrite_prevRow", WMAX'(patA));
    tick();
    popCheck(WMAX'(ifA.writeRow));
    popCheck(WMAX'(ifA.prevRow));
    ifA.reading = 0; ifA.displayActive = 0;
    tick();

    // full-row fill sweep; a request mid-window queues the next window
    ifA.displayActive = 1;
    for (int c = 0; c < 640; c++) begin
      ifA.column = 10'(c);
      ifA.drawRequest = (c == 100);
      tick();
    end
    ifA.drawRequest = 0; ifA.displayActive = 0;
    expRowA = onesA;
    push("fill_writeRow", WMAX'(expRowA));  popCheck(WMAX'(ifA.writeRow));
    push("fill_no_early_done", '0);        popCheck(WMAX'(ifA.frameDone));
    push("fill_still_drawing", WMAX'(1'b1)); popCheck(WMAX'(ifA.drawing));

    ifA.row = 9'd480;
    push("stop_drawing", '0);
    push("stop_frameDone", WMAX'(1'b1));
    tick();
    popCheck(WMAX'(ifA.drawing));
    popCheck(WMAX'(ifA.frameDone));
    push("stop_frameDone_pulse_end", '0);
    tick();
    popCheck(WMAX'(ifA.frameDone));
    push("frameDone_count1", WMAX'(1));  popCheck(WMAX'(fdA));

    // queued request waits for the start row, then opens a clear window
    ifA.row = 9'd0;
    push("queued_waits", '0);
    repeat (2) tick();
    popCheck(WMAX'(ifA.drawing));
    ifA.row = 9'd481;
    push("queued_start", WMAX'(1'b1));
    tick();
    popCheck(WMAX'(ifA.drawing));
    ifA.row = 9'd0; ifA.displayActive = 1;
    ifA.column = 10'd10;  tick();
    ifA.column = 10'd640; tick();
    ifA.column = 10'd1023; tick();
    ifA.column = 10'd639; tick();
    ifA.displayActive = 0;
    expRowA[10] = 1'b0; expRowA[639] = 1'b0;
    push("clear_writeRow", WMAX'(expRowA));
    popCheck(WMAX'(ifA.writeRow));
    ifA.row = 9'd480; tick(); tick();

    // noise window: pixels come from the LFSR value present before each edge
    ifA.mode = 2'd0; ifA.row = 9'd481; ifA.drawRequest = 1;
    tick();
    ifA.drawRequest = 0;
    tick();
    ifA.row = 9'd0; ifA.displayActive = 1;
    for (int c = 0; c < 16; c++) begin
      ifA.noise = 1'($urandom_range(0, 1));
      ifA.column = 10'(c);
      expRowA[c] = modelLfsr[0];
      tick();
    end
    ifA.displayActive = 0; ifA.noise = 0;
    push("noise_writeRow", WMAX'(expRowA));
    popCheck(WMAX'(ifA.writeRow));
    ifA.row = 9'd480; tick(); tick();

    // invert window over a loaded 0xA5 pattern; mode input changes after start
    prevExpA = expRowA;
    ifA.readRow = patA; ifA.reading = 1;
    tick();
    ifA.reading = 0;
    push("inv_load_prevRow", WMAX'(prevExpA));
    popCheck(WMAX'(ifA.prevRow));
    ifA.mode = 2'd3; ifA.row = 9'd481; ifA.drawRequest = 1;
    tick();
    ifA.drawRequest = 0;
    tick();
    ifA.mode = 2'd1; ifA.row = 9'd0; ifA.displayActive = 1;
    for (int c = 0; c < 640; c++) begin
      ifA.column = 10'(c);
      tick();
    end
    ifA.displayActive = 0;
`ifdef ROW_COMPOSITOR_INVERT_EN
    expRowA = ~patA;
`else
    expRowA = patA;
`endif
    push("invert_writeRow", WMAX'(expRowA));
    popCheck(WMAX'(ifA.writeRow));
    ifA.row = 9'd480;
    push("invert_frameDone", WMAX'(1'b1));
    tick();
    popCheck(WMAX'(ifA.frameDone));
    tick();
    push("frameDone_count4", WMAX'(4)); popCheck(WMAX'(fdA));

    // 4bpp instance: clear mode with out-of-range and edge columns
    ifB.readRow = '1; ifB.reading = 1;
    tick();
    ifB.reading = 0;
    ifB.mode = 2'd2; ifB.row = 9'd481; ifB.drawRequest = 1;
    tick();
    ifB.drawRequest = 0;
    push("b_start_drawing", WMAX'(1'b1));
    tick();
    popCheck(WMAX'(ifB.drawing));
    ifB.row = 9'd0; ifB.displayActive = 1;
    expRowB = '1;
    ifB.column = 10'd700;
    push("b_col700_unchanged", WMAX'(expRowB));
    tick();
    popCheck(WMAX'(ifB.writeRow));
    ifB.column = 10'd5;
    expRowB[23:20] = 4'h0;
    push("b_col5_pixel", WMAX'(4'h0));
    push("b_col5_row", WMAX'(expRowB));
    tick();
    popCheck(WMAX'(ifB.writeRow[23:20]));
    popCheck(WMAX'(ifB.writeRow));
    ifB.column = 10'd640; tick();
    ifB.column = 10'd639;
    expRowB[2559:2556] = 4'h0;
    push("b_col639_row", WMAX'(expRowB));
    tick();
    popCheck(WMAX'(ifB.writeRow));
    ifB.displayActive = 0;

    // reset during an open window with a queued request
    ifA.mode = 2'd1; ifA.row = 9'd481; ifA.drawRequest = 1;
    tick();
    ifA.drawRequest = 0;
    tick();
    ifA.row = 9'd0; ifA.drawRequest = 1;
    tick();
    ifA.drawRequest = 0;
    push("pre_rst_drawing", WMAX'(1'b1)); popCheck(WMAX'(ifA.drawing));
    rst = 1'b1;
    #1;
    push("rst_mid_drawingA", '0);   popCheck(WMAX'(ifA.drawing));
    push("rst_mid_drawingB", '0);   popCheck(WMAX'(ifB.drawing));
    push("rst_mid_frameDone", '0);  popCheck(WMAX'(ifA.frameDone));
    push("rst_mid_writeRow", '0);   popCheck(WMAX'(ifA.writeRow));
    tick();
    rst = 1'b0;
    ifA.row = 9'd480; ifB.row = 9'd480;
    tick();
    push("post_rst_no_doneA", '0);  popCheck(WMAX'(ifA.frameDone));
    push("post_rst_no_doneB", '0);  popCheck(WMAX'(ifB.frameDone));
    tick();
    ifA.row = 9'd481; ifB.row = 9'd481;
    repeat (3) tick();
    push("pending_discardedA", '0); popCheck(WMAX'(ifA.drawing));
    push("pending_discardedB", '0); popCheck(WMAX'(ifB.drawing));
    push("frameDone_count_after_rst", WMAX'(4)); popCheck(WMAX'(fdA));

    // long run with noise tied low
    ifA.noise = 0;
    zeroHits = 0; modelMiss = 0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (dutA.lfsr == 16'h0000) zeroHits++;
      if (dutA.lfsr !== modelLfsr) modelMiss++;
    end
    push("lfsr_zero_hits", '0);   popCheck(WMAX'(zeroHits));
    push("lfsr_model_miss", '0);  popCheck(WMAX'(modelMiss));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
